// File: rtl/can_pkg.sv
// Shared types and constants for the CAN frame receiver and the CAN CRC-15 block.
package can_pkg;

  localparam int ID_W     = 11;
  localparam int DLC_W    = 4;
  localparam int CRC_W    = 15;
  localparam int EOF_LEN  = 7;
  localparam int IDLE_LEN = 11;
  localparam int ARB_LEN  = ID_W + 1;   // identifier plus RTR
  localparam int CTRL_LEN = 6;          // IDE, r0, DLC[3:0]
  localparam int IFS_LEN  = 3;

  localparam logic [CRC_W-1:0] CRC_POLY = 15'h4599;

  typedef enum logic [3:0] {
    BUS_SYNC,
    IDLE,
    ARB,
    CTRL,
    DATA,
    CRC,
    CRC_DELIM,
    ACK,
    ACK_DELIM,
    EOF,
    INTERMISSION
  } rx_state_e;

  typedef enum logic [2:0] {
    ERR_NONE  = 3'd0,
    ERR_STUFF = 3'd1,
    ERR_FORM  = 3'd2,
    ERR_CRC   = 3'd3,
    ERR_DLC   = 3'd4
  } err_code_e;

  // One bit-serial CRC-15 step, MSB-first.
  function automatic logic [CRC_W-1:0] crc15_next(input logic [CRC_W-1:0] crc,
                                                  input logic            din);
    logic feedback;
    feedback = din ^ crc[CRC_W-1];
    return {crc[CRC_W-2:0], 1'b0} ^ (feedback ? CRC_POLY : '0);
  endfunction

endpackage

// File: rtl/can_crc15.sv
// Bit-serial CAN CRC-15 accumulator; clear restarts from zero and may coincide
// with enable, in which case the bit is folded into a fresh register.
module can_crc15
  import can_pkg::*;
(
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             enable,
  input  logic             clear,
  input  logic             din,
  output logic [CRC_W-1:0] crc
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      crc <= '0;
    end else if (enable) begin
      crc <= crc15_next(clear ? '0 : crc, din);
    end else if (clear) begin
      crc <= '0;
    end
  end

endmodule

// File: rtl/can_frame_receiver.sv
// CAN 2.0A (base format) frame receiver: bus sync, destuffing, field capture.
// Define CAN_RX_CRC_CHECK_EN to compare the received CRC and abort on mismatch.
module can_frame_receiver
  import can_pkg::*;
(
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             serial_i,
  output logic             valid_o,
  output logic [ID_W-1:0]  msg_id_o,
  output logic             rtr_o,
  output logic [DLC_W-1:0] dlc_o,
  output logic [31:0]      data_o,
  output logic             error_o,
  output logic [2:0]       err_code_o,
  output logic             busy_o
);

  localparam logic [5:0] SYNC_LAST = 6'(IDLE_LEN - 1);
  localparam logic [5:0] ARB_LAST  = 6'(ARB_LEN - 1);
  localparam logic [5:0] CTRL_LAST = 6'(CTRL_LEN - 1);
  localparam logic [5:0] CRC_LAST  = 6'(CRC_W - 1);
  localparam logic [5:0] EOF_LAST  = 6'(EOF_LEN - 1);
  localparam logic [5:0] IFS_LAST  = 6'(IFS_LEN - 1);

  rx_state_e        state, state_nxt;
  logic [5:0]       bit_cnt, cnt_nxt;
  logic [2:0]       run_cnt;
  logic             last_bit;
  logic [ID_W-1:0]  id_q;
  logic             rtr_q;
  logic [DLC_W-1:0] dlc_q;
  logic [31:0]      data_q;

  logic             field_state, stuff_slot, stuff_err, data_bit, sof;
  logic             abort, frame_done, crc_bad;
  err_code_e        abort_code;
  logic [DLC_W-1:0] dlc_nxt;
  logic [5:0]       data_last;

  assign field_state = state inside {ARB, CTRL, DATA, CRC};
  // A stuff bit may still trail the last CRC bit, so CRC_DELIM inherits a pending slot.
  assign stuff_slot  = (run_cnt == 3'd5) && (field_state || state == CRC_DELIM);
  assign stuff_err   = stuff_slot && (serial_i == last_bit);
  assign data_bit    = field_state && !stuff_slot;
  assign sof         = (state == IDLE) && !serial_i;
  assign dlc_nxt     = {dlc_q[DLC_W-2:0], serial_i};
  assign data_last   = {dlc_q[2:0], 3'b000} - 6'd1;
  assign busy_o      = field_state || (state inside {CRC_DELIM, ACK, ACK_DELIM, EOF});

`ifdef CAN_RX_CRC_CHECK_EN
  logic [CRC_W-1:0] crc_calc, crc_rx;
  logic             crc_en;

  assign crc_en = sof || (data_bit && state inside {ARB, CTRL, DATA});

  can_crc15 u_crc (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .enable  (crc_en),
    .clear   (sof),
    .din     (serial_i),
    .crc     (crc_calc)
  );

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      crc_rx <= '0;
    end else if (sof) begin
      crc_rx <= '0;
    end else if (data_bit && state == CRC) begin
      crc_rx <= {crc_rx[CRC_W-2:0], serial_i};
    end
  end

  assign crc_bad = ({crc_rx[CRC_W-2:0], serial_i} != crc_calc);
`else
  assign crc_bad = 1'b0;
`endif

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state   <= BUS_SYNC;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= cnt_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = bit_cnt;
    abort      = 1'b0;
    abort_code = ERR_NONE;
    frame_done = 1'b0;

    case (state)
      BUS_SYNC: begin
        if (!serial_i) begin
          cnt_nxt = '0;
        end else if (bit_cnt == SYNC_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = bit_cnt + 6'd1;
        end
      end
      IDLE: begin
        if (sof) begin
          state_nxt = ARB;
          cnt_nxt   = '0;
        end
      end
      ARB: begin
        if (data_bit) begin
          if (bit_cnt == ARB_LAST) begin
            state_nxt = CTRL;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = bit_cnt + 6'd1;
          end
        end
      end
      CTRL: begin
        if (data_bit) begin
          if (bit_cnt == 6'd0 && serial_i) begin
            abort      = 1'b1;
            abort_code = ERR_FORM;
          end else if (bit_cnt == CTRL_LAST) begin
            cnt_nxt = '0;
            if (!rtr_q && dlc_nxt > 4'd4) begin
              abort      = 1'b1;
              abort_code = ERR_DLC;
            end else if (rtr_q || dlc_nxt == '0) begin
              state_nxt = CRC;
            end else begin
              state_nxt = DATA;
            end
          end else begin
            cnt_nxt = bit_cnt + 6'd1;
          end
        end
      end
      DATA: begin
        if (data_bit) begin
          if (bit_cnt == data_last) begin
            state_nxt = CRC;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = bit_cnt + 6'd1;
          end
        end
      end
      CRC: begin
        if (data_bit) begin
          if (bit_cnt == CRC_LAST) begin
            cnt_nxt = '0;
            if (crc_bad) begin
              abort      = 1'b1;
              abort_code = ERR_CRC;
            end else begin
              state_nxt = CRC_DELIM;
            end
          end else begin
            cnt_nxt = bit_cnt + 6'd1;
          end
        end
      end
      CRC_DELIM: begin
        if (!stuff_slot) begin
          if (!serial_i) begin
            abort      = 1'b1;
            abort_code = ERR_FORM;
          end else begin
            state_nxt = ACK;
          end
        end
      end
      ACK: state_nxt = ACK_DELIM;
      ACK_DELIM: begin
        if (!serial_i) begin
          abort      = 1'b1;
          abort_code = ERR_FORM;
        end else begin
          state_nxt = EOF;
          cnt_nxt   = '0;
        end
      end
      EOF: begin
        if (!serial_i) begin
          abort      = 1'b1;
          abort_code = ERR_FORM;
        end else if (bit_cnt == EOF_LAST) begin
          frame_done = 1'b1;
          state_nxt  = INTERMISSION;
          cnt_nxt    = '0;
        end else begin
          cnt_nxt = bit_cnt + 6'd1;
        end
      end
      INTERMISSION: begin
        if (!serial_i) begin
          state_nxt = BUS_SYNC;
          cnt_nxt   = '0;
        end else if (bit_cnt == IFS_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = bit_cnt + 6'd1;
        end
      end
      default: begin
        state_nxt = BUS_SYNC;
        cnt_nxt   = '0;
      end
    endcase

    if (stuff_err) begin
      abort      = 1'b1;
      abort_code = ERR_STUFF;
    end
    if (abort) begin
      state_nxt = BUS_SYNC;
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      run_cnt  <= '0;
      last_bit <= 1'b0;
    end else if (sof) begin
      run_cnt  <= 3'd1;
      last_bit <= 1'b0;
    end else if (stuff_slot) begin
      run_cnt  <= 3'd1;
      last_bit <= serial_i;
    end else if (data_bit) begin
      if (serial_i == last_bit) begin
        run_cnt <= run_cnt + 3'd1;
      end else begin
        run_cnt  <= 3'd1;
        last_bit <= serial_i;
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      id_q   <= '0;
      rtr_q  <= 1'b0;
      dlc_q  <= '0;
      data_q <= '0;
    end else if (sof) begin
      data_q <= '0;
    end else if (data_bit) begin
      case (state)
        ARB:  {id_q, rtr_q} <= {id_q[ID_W-2:0], rtr_q, serial_i};
        CTRL: dlc_q <= dlc_nxt;
        // Data bit n lands at 31-n so the first byte ends up in [31:24].
        DATA: data_q[~bit_cnt[4:0]] <= serial_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      valid_o    <= 1'b0;
      error_o    <= 1'b0;
      err_code_o <= '0;
      msg_id_o   <= '0;
      rtr_o      <= 1'b0;
      dlc_o      <= '0;
      data_o     <= '0;
    end else begin
      valid_o <= frame_done;
      error_o <= abort;
      if (abort) begin
        err_code_o <= abort_code;
      end
      if (frame_done) begin
        msg_id_o <= id_q;
        rtr_o    <= rtr_q;
        dlc_o    <= dlc_q;
        data_o   <= data_q;
      end
    end
  end

endmodule

// File: doc/can_frame_receiver.md
CAN_FRAME_RECEIVER -- requirements
Module: can_frame_receiver

Interface
REQ-001 SHALL have ports: clock_i  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have ports: reset_i  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have ports: serial_i  input  1  CAN bus bit stream, one bit per clock; 0 = dominant, 1 = recessive.
REQ-004 SHALL have ports: valid_o  output  1  one-cycle pulse; frame received without error.
REQ-005 SHALL have ports: msg_id_o  output  11  received identifier; held until next valid_o.
REQ-006 SHALL have ports: rtr_o  output  1  received RTR bit; held until next valid_o.
REQ-007 SHALL have ports: dlc_o  output  4  received DLC; held until next valid_o.
REQ-008 SHALL have ports: data_o  output  32  data bytes, first byte in [31:24], unused low bytes zero; held until next valid_o.
REQ-009 SHALL have ports: error_o  output  1  one-cycle pulse; frame aborted.
REQ-010 SHALL have ports: err_code_o  output  3  cause, valid with error_o: 1 STUFF, 2 FORM, 3 CRC, 4 DLC.
REQ-011 SHALL have ports: busy_o  output  1  high from SOF sample until frame end or abort.

Function
REQ-012 SHALL use states BUS_SYNC, IDLE, ARB, CTRL, DATA, CRC, CRC_DELIM, ACK, ACK_DELIM, EOF, INTERMISSION.
REQ-013 BUS_SYNC SHALL count consecutive 1 samples; at 11 go IDLE; any 0 restarts the count.
REQ-014 IDLE SHALL treat a 0 sample as SOF and go ARB; SOF counts as the first stuffable bit.
REQ-015 ARB SHALL shift 12 destuffed bits, ID MSB first, then RTR; CTRL SHALL shift IDE, r0, DLC[3:0] (6 bits).
REQ-016 IDE = 1 SHALL abort FORM; DLC > 4 with RTR = 0 SHALL abort DLC; DLC > 4 with RTR = 1 SHALL be accepted.
REQ-017 DATA SHALL shift 8*DLC bits; DATA SHALL be skipped when RTR = 1 or DLC = 0.
REQ-018 CRC SHALL shift 15 bits, MSB first.
REQ-019 Destuffing SHALL apply from SOF through the last CRC bit, inclusive of a stuff bit that follows the last CRC bit.
REQ-020 Destuffing: after 5 equal consecutive bits, the next bit SHALL be dropped if opposite; if equal, abort STUFF. Run count resets to 1 with the stuff bit's value.
REQ-021 CRC-15 (poly 0x4599, init 0) SHALL be computed over destuffed bits SOF through last data bit.
REQ-022 CRC_DELIM, ACK_DELIM and each of 7 EOF bits SHALL be 1, else abort FORM.
REQ-023 ACK SHALL accept either value; the receiver never drives the bus.
REQ-024 valid_o SHALL pulse in the cycle after the 7th EOF bit is sampled; output registers update in that same cycle.
REQ-025 After EOF, state SHALL go INTERMISSION, require 3 samples of 1, then go IDLE; a 0 during INTERMISSION SHALL go BUS_SYNC without error.
REQ-026 Any abort SHALL pulse error_o with err_code_o for one cycle, leave msg_id_o/rtr_o/dlc_o/data_o unchanged, and go BUS_SYNC.
REQ-027 valid_o and error_o SHALL never be high in the same cycle.

Reset
REQ-028 Reset SHALL force state BUS_SYNC and clear all counters and the CRC register.
REQ-029 Reset SHALL drive valid_o, error_o and busy_o to 0, and msg_id_o, rtr_o, dlc_o, data_o and err_code_o to 0.
REQ-030 Reset asserted mid-frame SHALL discard the frame with no valid_o or error_o pulse.

Configuration
REQ-031 Macro CAN_RX_CRC_CHECK_EN defined: a CRC mismatch SHALL abort with code 3, checked when the last CRC bit is sampled.
REQ-032 Macro CAN_RX_CRC_CHECK_EN undefined: the CRC field SHALL still be consumed and destuffed but not compared; code 3 SHALL never be produced; the CRC sub-module SHALL not be instantiated.

Structure
REQ-033 Package can_pkg SHALL hold the state enum, the error-code enum, CRC_POLY = 15'h4599, and field widths ID_W = 11, DLC_W = 4, CRC_W = 15, EOF_LEN = 7, IDLE_LEN = 11.
REQ-034 The CRC SHALL be a sub-module can_crc15 (bit-serial, enable/clear/bit in, 15-bit out), reusable by the transmitter.

Verification
REQ-035 Frame ID 0x123, RTR 0, DLC 4, data 0xDEADBEEF, CRC 0x4E6B, stuffed, then 7 EOF and 7 IFS 1s -> single valid_o; msg_id_o = 0x123, dlc_o = 4, data_o = 0xDEADBEEF.
REQ-036 Same frame with the 6th of 6 equal bits left unstuffed -> error_o, code 1; outputs keep their previous values.
REQ-037 Same frame with CRC bit 0 flipped (stuffing recomputed) -> error_o, code 3 with the macro defined; valid_o without it.
REQ-038 ID 0x7FF, RTR 1, DLC 8 -> valid_o, rtr_o = 1, data_o = 0; ID 0x001, RTR 0, DLC 5 -> error_o, code 4.
REQ-039 3rd EOF bit forced 0 -> error_o, code 2; a following good frame is accepted only after 11 recessive bits.
REQ-040 reset_i pulled low mid-DATA -> no pulse, outputs 0, busy_o = 0; a subsequent good frame is received correctly.
